dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 153 +++++++++++++++
 tb/tb_dmem_lsu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Single-ported word-array load/store unit: byte/half/word access with alignment and range faults.
// Latency RD_LATENCY cycles for loads, 1 cycle for stores/faults; one outstanding request, response held until rsp_ready.
module dmem_lsu #(
    parameter int MEM_SIZE_WORDS = 256,
    parameter int RD_LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr_en,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd_data,
    output logic [1:0]  rsp_fault
);
    localparam int AW = $clog2(MEM_SIZE_WORDS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_READ_WAIT = 2'd1;
    localparam logic [1:0] S_RESP      = 2'd2;

    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

    logic [31:0]   mem_q [MEM_SIZE_WORDS];
    logic [1:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    size_q, off_q, fault_q;
    logic          uns_q;
    logic [31:0]   word_q;

    logic          accept;
    logic [1:0]    req_fault;
    logic [AW-1:0] mem_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_lanes;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign accept  = req_valid && (state_q == S_IDLE);
    assign mem_idx = req_addr[AW+1:2];

    always_comb begin
        req_fault = 2'b00;
        if (req_size == 2'b11)
            req_fault = 2'b01;
        else if ((req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00))
            req_fault = 2'b10;
        else if (req_addr[31:2] >= 30'(MEM_SIZE_WORDS))
            req_fault = 2'b11;
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = req_wr_data;
        case (req_size)
            2'b00: begin
                wr_be    = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wr_data[7:0]}};
            end
            2'b01: begin
                wr_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{req_wr_data[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_wr_en && req_fault == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem_q[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_wr_en && req_fault == 2'b00 && RD_LATENCY > 1) begin
                        state_d = S_READ_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_READ_WAIT: begin
                if (cnt_q == 2'd0)
                    state_d = S_RESP;
                else
                    cnt_d = cnt_q - 2'd1;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            fault_q <= 2'b00;
            uns_q   <= 1'b0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                size_q  <= req_size;
                off_q   <= req_addr[1:0];
                fault_q <= req_fault;
                uns_q   <= req_unsigned;
                // A zero word makes store and fault responses read back as zero without extra muxing.
                word_q  <= (!req_wr_en && req_fault == 2'b00) ? mem_q[mem_idx] : 32'd0;
            end
        end
    end

    always_comb begin
        ld_byte = word_q[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? word_q[31:16] : word_q[15:0];
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = word_q;
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rd_data = rsp_valid ? ld_data : 32'd0;
    assign rsp_fault   = rsp_valid ? fault_q : 2'b00;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: instance a uses RD_LATENCY=1, instance b uses RD_LATENCY=3, both 256 words.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr;
    logic        req_wr_en;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wr_data;
    logic        rsp_ready;

    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_rd_data_a, rsp_rd_data_b;
    logic [1:0]  rsp_fault_a, rsp_fault_b;

    logic        sel_b;
    logic        cur_rdy, cur_vld;
    logic [31:0] cur_dat;
    logic [1:0]  cur_flt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.MEM_SIZE_WORDS(256), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_addr(req_addr), .req_wr_en(req_wr_en), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rd_data(rsp_rd_data_a), .rsp_fault(rsp_fault_a)
    );

    dmem_lsu #(.MEM_SIZE_WORDS(256), .RD_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_wr_en(req_wr_en), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wr_data(req_wr_data),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rd_data(rsp_rd_data_b), .rsp_fault(rsp_fault_b)
    );

    assign cur_rdy = sel_b ? req_ready_b   : req_ready_a;
    assign cur_vld = sel_b ? rsp_valid_b   : rsp_valid_a;
    assign cur_dat = sel_b ? rsp_rd_data_b : rsp_rd_data_a;
    assign cur_flt = sel_b ? rsp_fault_b   : rsp_fault_a;

    typedef struct {
        string       name;
        bit          sel;
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_flt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit sel, input bit wr, input logic [1:0] sz,
                                input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic [1:0] exp_flt, input int exp_lat);
        vec_t v;
        v.name = name; v.sel = sel; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wd = wd; v.exp_rd = exp_rd; v.exp_flt = exp_flt; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        @(negedge clk);
        sel_b = v.sel;
        #1;
        chk({v.name, ".req_ready"}, {31'd0, cur_rdy}, 32'd1);
        req_addr     = v.addr;
        req_wr_en    = v.wr;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_wr_data  = v.wd;
        req_valid_a  = !v.sel;
        req_valid_b  = v.sel;
        @(posedge clk);
        #1;
        // Scramble every request field so a response built from live inputs shows up.
        req_valid_a  = 1'b0;
        req_valid_b  = 1'b0;
        req_addr     = ~v.addr;
        req_wr_en    = ~v.wr;
        req_size     = ~v.sz;
        req_unsigned = ~v.uns;
        req_wr_data  = ~v.wd;
    endtask

    task automatic wait_rsp(input string name, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (cur_vld) got = 1'b1;
        end
        if (!got) chk({name, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        issue(v);
        wait_rsp(v.name, lat, got);
        if (got) begin
            chk({v.name, ".rd_data"}, cur_dat, v.exp_rd);
            chk({v.name, ".fault"}, {30'd0, cur_flt}, {30'd0, v.exp_flt});
            chk({v.name, ".latency"}, lat, v.exp_lat);
            finish_rsp();
        end
    endtask

    initial begin
        int  lat;
        bit  got;
        logic [31:0] held;

        rst_n = 1'b0; rsp_ready = 1'b0; sel_b = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0; req_addr = '0; req_wr_en = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wr_data = '0;

        vecs.push_back(mk("st_w_10",      0, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        2'b00, 1));
        vecs.push_back(mk("ld_b_s_13",    0, 0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 2'b00, 1));
        vecs.push_back(mk("ld_b_u_10",    0, 0, 2'b00, 1, 32'h10,  32'h0,        32'h000000EF, 2'b00, 1));
        vecs.push_back(mk("ld_b_s_11",    0, 0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 2'b00, 1));
        vecs.push_back(mk("ld_b_u_12",    0, 0, 2'b00, 1, 32'h12,  32'h0,        32'h000000AD, 2'b00, 1));
        vecs.push_back(mk("ld_h_s_12",    0, 0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 2'b00, 1));
        vecs.push_back(mk("ld_h_u_10",    0, 0, 2'b01, 1, 32'h10,  32'h0,        32'h0000BEEF, 2'b00, 1));
        vecs.push_back(mk("st_w_20",      0, 1, 2'b10, 0, 32'h20,  32'h12345678, 32'h0,        2'b00, 1));
        vecs.push_back(mk("st_h_22",      0, 1, 2'b01, 0, 32'h22,  32'hAAAA8001, 32'h0,        2'b00, 1));
        vecs.push_back(mk("ld_h_u_22",    0, 0, 2'b01, 1, 32'h22,  32'h0,        32'h00008001, 2'b00, 1));
        vecs.push_back(mk("ld_h_s_22",    0, 0, 2'b01, 0, 32'h22,  32'h0,        32'hFFFF8001, 2'b00, 1));
        vecs.push_back(mk("ld_w_20",      0, 0, 2'b10, 0, 32'h20,  32'h0,        32'h80015678, 2'b00, 1));
        vecs.push_back(mk("ld_w_06_mis",  0, 0, 2'b10, 0, 32'h06,  32'h0,        32'h0,        2'b10, 1));
        vecs.push_back(mk("st_w_00",      0, 1, 2'b10, 0, 32'h00,  32'h11223344, 32'h0,        2'b00, 1));
        vecs.push_back(mk("st_h_01_mis",  0, 1, 2'b01, 0, 32'h01,  32'h0000FFFF, 32'h0,        2'b10, 1));
        vecs.push_back(mk("ld_w_00_a",    0, 0, 2'b10, 0, 32'h00,  32'h0,        32'h11223344, 2'b00, 1));
        vecs.push_back(mk("ld_sz3_03",    0, 0, 2'b11, 0, 32'h03,  32'h0,        32'h0,        2'b01, 1));
        vecs.push_back(mk("st_sz3_10",    0, 1, 2'b11, 0, 32'h10,  32'h0,        32'h0,        2'b01, 1));
        vecs.push_back(mk("ld_w_10_a",    0, 0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00, 1));
        vecs.push_back(mk("prio_sz3",     0, 0, 2'b11, 0, 32'h401, 32'h0,        32'h0,        2'b01, 1));
        vecs.push_back(mk("prio_mis",     0, 0, 2'b10, 0, 32'h402, 32'h0,        32'h0,        2'b10, 1));
        vecs.push_back(mk("st_w_400_oor", 0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        2'b11, 1));
        vecs.push_back(mk("ld_b_400_oor", 0, 0, 2'b00, 0, 32'h400, 32'h0,        32'h0,        2'b11, 1));
        vecs.push_back(mk("ld_w_00_b",    0, 0, 2'b10, 0, 32'h00,  32'h0,        32'h11223344, 2'b00, 1));
        vecs.push_back(mk("st_w_3fc",     0, 1, 2'b10, 0, 32'h3FC, 32'h5A5AA5A5, 32'h0,        2'b00, 1));
        vecs.push_back(mk("ld_w_3fc",     0, 0, 2'b10, 0, 32'h3FC, 32'h0,        32'h5A5AA5A5, 2'b00, 1));
        vecs.push_back(mk("st_b_11",      0, 1, 2'b00, 0, 32'h11,  32'hFFFFFF77, 32'h0,        2'b00, 1));
        vecs.push_back(mk("ld_w_10_b",    0, 0, 2'b10, 0, 32'h10,  32'h0,        32'hDEAD77EF, 2'b00, 1));
        vecs.push_back(mk("b_st_w_40",    1, 1, 2'b10, 0, 32'h40,  32'h0BADCAFE, 32'h0,        2'b00, 1));
        vecs.push_back(mk("b_ld_w_40",    1, 0, 2'b10, 0, 32'h40,  32'h0,        32'h0BADCAFE, 2'b00, 3));
        vecs.push_back(mk("b_ld_b_s_43",  1, 0, 2'b00, 0, 32'h43,  32'h0,        32'h0000000B, 2'b00, 3));
        vecs.push_back(mk("b_ld_b_s_42",  1, 0, 2'b00, 0, 32'h42,  32'h0,        32'hFFFFFFAD, 2'b00, 3));
        vecs.push_back(mk("b_ld_h_u_42",  1, 0, 2'b01, 1, 32'h42,  32'h0,        32'h00000BAD, 2'b00, 3));
        vecs.push_back(mk("b_ld_w_41_mis",1, 0, 2'b10, 0, 32'h41,  32'h0,        32'h0,        2'b10, 1));

        repeat (2) @(negedge clk);
        chk("rst.rsp_valid_a", {31'd0, rsp_valid_a}, 32'd0);
        chk("rst.rsp_valid_b", {31'd0, rsp_valid_b}, 32'd0);
        chk("rst.rd_data_a", rsp_rd_data_a, 32'd0);
        chk("rst.fault_b", {30'd0, rsp_fault_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.req_ready_a", {31'd0, req_ready_a}, 32'd1);
        chk("rst.req_ready_b", {31'd0, req_ready_b}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Held response on the 3-cycle instance must stay frozen while rsp_ready is low.
        issue(mk("hold", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 2'b00, 3));
        wait_rsp("hold", lat, got);
        if (got) begin
            chk("hold.latency", lat, 3);
            held = cur_dat;
            chk("hold.data", held, 32'h0BADCAFE);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("hold.valid", {31'd0, cur_vld}, 32'd1);
                chk("hold.stable", cur_dat, 32'h0BADCAFE);
                chk("hold.fault", {30'd0, cur_flt}, 32'd0);
                chk("hold.req_ready", {31'd0, cur_rdy}, 32'd0);
            end
            finish_rsp();
            @(negedge clk);
            chk("hold.after_valid", {31'd0, cur_vld}, 32'd0);
            chk("hold.after_ready", {31'd0, cur_rdy}, 32'd1);
        end

        // Reset while a load sits in READ_WAIT.
        issue(mk("rstwait", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 2'b00, 3));
        @(negedge clk);
        chk("rstwait.valid_pre", {31'd0, cur_vld}, 32'd0);
        chk("rstwait.ready_pre", {31'd0, cur_rdy}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstwait.valid_in_rst", {31'd0, cur_vld}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstwait.ready_after", {31'd0, cur_rdy}, 32'd1);
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cur_vld) got = 1'b1;
        end
        chk("rstwait.no_valid", {31'd0, got}, 32'd0);
        run_vec(mk("rstwait.ld_b_40", 1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0BADCAFE, 2'b00, 3));
        run_vec(mk("rstwait.ld_a_10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD77EF, 2'b00, 1));
        run_vec(mk("rstwait.ld_a_20", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h80015678, 2'b00, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
